// File: rtl/v_alu_wb_buffer.sv
// Result buffer between the ALU pipeline and the vector register file / scalar consumer.
// In-order FIFO of ALU results plus an issue credit counter bounding launched-but-unretired ops.
module v_alu_wb_buffer #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_fire,
    output logic                  issue_ok,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_vec,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic                  in_w_reg,
    input  logic                  in_sca,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic [ADDR_WIDTH-1:0] wb_addr,
    output logic                  wb_w_reg,
    output logic                  sca_valid,
    input  logic                  sca_ready,
    output logic                  err_overflow,
    output logic                  err_credit
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W = DATA_WIDTH + ADDR_WIDTH + 2;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] outstanding;
    logic [ENT_W-1:0] head;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push;
    logic             launch;

    // Entry layout: {vec, addr, w_reg, sca}
    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // Head presentation depends only on registered state
    assign wb_valid  = !empty && !head[0];
    assign sca_valid = !empty &&  head[0];
    assign wb_w_reg  = !empty &&  head[1];
    assign wb_addr   = empty ? '0 : head[ADDR_WIDTH+1:2];
    assign wb_data   = empty ? '0 : head[ENT_W-1:ADDR_WIDTH+2];
    assign issue_ok  = (outstanding < CNT_W'(DEPTH));

    assign pop    = (wb_valid && wb_ready) || (sca_valid && sca_ready);
    assign push   = in_valid && (!full || pop);
    assign launch = issue_fire && issue_ok;

    // Storage carries no reset; empty gating hides stale contents
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_vec, in_addr, in_w_reg, in_sca};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            outstanding  <= '0;
            err_overflow <= 1'b0;
            err_credit   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            // A retire with no credit outstanding is a protocol error; hold at zero
            if (launch && !pop) begin
                outstanding <= outstanding + CNT_W'(1);
            end else if (pop && !launch && outstanding != '0) begin
                outstanding <= outstanding - CNT_W'(1);
            end
            if (in_valid && full && !pop) begin
                err_overflow <= 1'b1;
            end
            if (issue_fire && !issue_ok) begin
                err_credit <= 1'b1;
            end
        end
    end

endmodule
